// File: rtl/peripherals_bus_mux.sv
// Purpose : registered address decoder / bus mux between the core I/O port and
//           NUM_SLAVES peripherals, with unmapped-address errors, a per-access
//           timeout and a prioritised, registered interrupt code.
// Latency : request sampled at edge 0, slv_sel after edge 1, io_ready one edge
//           after the selected slv_ready is sampled (min 3 cycles); unmapped
//           accesses complete with io_ready after edge 2.
// Backpressure: one access in flight; the requester holds io_read/io_write until
//           io_ready, and must drop them before the next access is accepted.
//
// Ports:
//   pclk, rst          clock, synchronous active-high reset
//   io_*               core-side request (addr/read/write/wdata/byte_size) and
//                      response (rdata/ready/err)
//   slv_sel/read/write one-hot select and strobes to the addressed slave
//   slv_addr/wdata/byte_size  registered request fields to the slaves
//   slv_rdata/ready    flat per-slave read data and completion
//   slv_int, int_code  level interrupts in, registered priority code out

module peripherals_bus_mux #(
    parameter int                          XLEN           = 32,
    parameter int                          NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*XLEN-1:0]  SLV_BASE       = {32'h3000_0000, 32'h2000_0000,
                                                             32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*XLEN-1:0]  SLV_MASK       = {4{32'hF000_0000}},
    parameter int                          TIMEOUT        = 255,
    parameter logic [XLEN-1:0]             ERR_DATA       = 32'hDEAD_BEEF,
    parameter int                          INT_CODE_WIDTH = 5
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic [XLEN-1:0]                io_addr,
    input  logic                           io_read,
    input  logic                           io_write,
    input  logic [XLEN-1:0]                io_wdata,
    input  logic [1:0]                     io_byte_size,
    output logic [XLEN-1:0]                io_rdata,
    output logic                           io_ready,
    output logic                           io_err,
    output logic [NUM_SLAVES-1:0]          slv_sel,
    output logic                           slv_read,
    output logic                           slv_write,
    output logic [XLEN-1:0]                slv_addr,
    output logic [XLEN-1:0]                slv_wdata,
    output logic [1:0]                     slv_byte_size,
    input  logic [NUM_SLAVES*XLEN-1:0]     slv_rdata,
    input  logic [NUM_SLAVES-1:0]          slv_ready,
    input  logic [NUM_SLAVES-1:0]          slv_int,
    output logic [INT_CODE_WIDTH-1:0]      int_code
);

    // Elaboration-time parameter sanity.
    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
        $error("peripherals_bus_mux: NUM_SLAVES must be 1..16");
    end
    if (NUM_SLAVES >= (1 << INT_CODE_WIDTH)) begin : g_bad_code_width
        $error("peripherals_bus_mux: INT_CODE_WIDTH too small for NUM_SLAVES+1 codes");
    end

    // A zero TIMEOUT disables the timeout; keep at least one counter bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ACCESS,
        S_RESP,
        S_ERR,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic                      r_write;   // captured op: 1 = write, 0 = read
    logic                      r_bad;     // read and write requested together
    logic                      r_err;     // access ended by timeout
    logic [XLEN-1:0]           r_data;    // captured slave read data
    logic [CNT_W-1:0]          r_cnt;

    logic [XLEN-1:0]           r_io_rdata;
    logic                      r_io_ready;
    logic                      r_io_err;
    logic [NUM_SLAVES-1:0]     r_slv_sel;
    logic                      r_slv_read;
    logic                      r_slv_write;
    logic [XLEN-1:0]           r_slv_addr;
    logic [XLEN-1:0]           r_slv_wdata;
    logic [1:0]                r_slv_size;
    logic [INT_CODE_WIDTH-1:0] r_int_code;

    logic                      w_hit;
    logic [NUM_SLAVES-1:0]     w_dec_sel;
    logic                      w_sel_ready;
    logic [XLEN-1:0]           w_sel_rdata;
    logic [INT_CODE_WIDTH-1:0] w_int_code;

    // Address decode on the registered address. Scanning from the top down
    // lets the lowest matching index overwrite any higher match.
    always_comb begin
        w_hit     = 1'b0;
        w_dec_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((r_slv_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
                w_hit        = 1'b1;
                w_dec_sel    = '0;
                w_dec_sel[i] = 1'b1;
            end
        end
    end

    // Only the selected slave's ready/data are visible; others are masked off.
    assign w_sel_ready = |(slv_ready & r_slv_sel);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_slv_sel[i]) begin
                w_sel_rdata = w_sel_rdata | slv_rdata[i*XLEN +: XLEN];
            end
        end
    end

    // Interrupt priority encode: lowest pending index wins, code = index + 1.
    always_comb begin
        w_int_code = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (slv_int[i]) begin
                w_int_code = INT_CODE_WIDTH'(i + 1);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_int_code <= '0;
        end else begin
            r_int_code <= w_int_code;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_bad       <= 1'b0;
            r_err       <= 1'b0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_io_rdata  <= '0;
            r_io_ready  <= 1'b0;
            r_io_err    <= 1'b0;
            r_slv_sel   <= '0;
            r_slv_read  <= 1'b0;
            r_slv_write <= 1'b0;
            r_slv_addr  <= '0;
            r_slv_wdata <= '0;
            r_slv_size  <= '0;
        end else begin
            // io_ready/io_err are single-cycle pulses.
            r_io_ready <= 1'b0;
            r_io_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (io_read || io_write) begin
                        r_slv_addr  <= io_addr;
                        r_slv_wdata <= io_wdata;
                        r_slv_size  <= io_byte_size;
                        r_write     <= io_write;
                        r_bad       <= io_read && io_write;
                        r_state     <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (w_hit && !r_bad) begin
                        r_slv_sel   <= w_dec_sel;
                        r_slv_read  <= !r_write;
                        r_slv_write <= r_write;
                        r_cnt       <= '0;
                        r_state     <= S_ACCESS;
                    end else begin
                        r_state <= S_ERR;
                    end
                end

                S_ACCESS: begin
                    if (w_sel_ready) begin
                        r_data      <= r_write ? '0 : w_sel_rdata;
                        r_err       <= 1'b0;
                        r_slv_sel   <= '0;
                        r_slv_read  <= 1'b0;
                        r_slv_write <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (TIMEOUT != 0 && r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // This cycle would bring the count to TIMEOUT: give up.
                        // A ready arriving on the same edge still wins above.
                        r_err       <= 1'b1;
                        r_slv_sel   <= '0;
                        r_slv_read  <= 1'b0;
                        r_slv_write <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    r_io_ready <= 1'b1;
                    r_io_err   <= r_err;
                    r_io_rdata <= r_err ? ERR_DATA : r_data;
                    r_state    <= S_DONE;
                end

                S_ERR: begin
                    r_io_ready <= 1'b1;
                    r_io_err   <= 1'b1;
                    r_io_rdata <= ERR_DATA;
                    r_state    <= S_DONE;
                end

                S_DONE: begin
                    // Hold off until the requester lets go, so a request that is
                    // still asserted is not issued a second time.
                    if (!io_read && !io_write) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_rdata      = r_io_rdata;
    assign io_ready      = r_io_ready;
    assign io_err        = r_io_err;
    assign slv_sel       = r_slv_sel;
    assign slv_read      = r_slv_read;
    assign slv_write     = r_slv_write;
    assign slv_addr      = r_slv_addr;
    assign slv_wdata     = r_slv_wdata;
    assign slv_byte_size = r_slv_size;
    assign int_code      = r_int_code;

endmodule

// File: doc/peripherals_bus_mux.md
Name: peripherals_bus_mux

Overview:
- Parametrised, registered successor to the single-level peripheral bus decoder; sits between the core I/O port and N peripheral slaves.
- Decodes each request against a parameter-defined base/mask address map and drives one slave through a request/ready handshake.
- Adds three behaviours the previous bus lacked: an error response for unmapped addresses, a per-access timeout, and prioritised interrupt aggregation with a registered interrupt code.

Parameters:
- XLEN, 32, data/address width.
- NUM_SLAVES, 4, number of slave channels (1..16).
- SLV_BASE, {NUM_SLAVES*XLEN}, flat vector; slave i base at bits [i*XLEN +: XLEN].
- SLV_MASK, {NUM_SLAVES*XLEN}, flat vector; slave i matches when (addr & mask_i) == base_i.
- TIMEOUT, 255, cycles allowed in ACCESS before an error response; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, io_rdata value returned on any error.
- INT_CODE_WIDTH, 5, width of int_code.

Ports:
- pclk  in  1  bus clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- io_addr  in  XLEN  request address.
- io_read  in  1  read request (level, held until io_ready).
- io_write  in  1  write request (level, held until io_ready).
- io_wdata  in  XLEN  write data.
- io_byte_size  in  2  access size, passed through to the slave.
- io_rdata  out  XLEN  read data, valid while io_ready=1.
- io_ready  out  1  one-cycle completion pulse.
- io_err  out  1  error flag, qualified by io_ready.
- slv_sel  out  NUM_SLAVES  one-hot slave select.
- slv_read  out  1  read strobe to the selected slave.
- slv_write  out  1  write strobe to the selected slave.
- slv_addr  out  XLEN  registered address.
- slv_wdata  out  XLEN  registered write data.
- slv_byte_size  out  2  registered size.
- slv_rdata  in  NUM_SLAVES*XLEN  flat slave read data.
- slv_ready  in  NUM_SLAVES  per-slave completion.
- slv_int  in  NUM_SLAVES  level interrupt requests.
- int_code  out  INT_CODE_WIDTH  interrupt code: 0 = none, else (lowest pending index + 1).

Behaviour:
- Reset (rst=1 at posedge): FSM goes to IDLE; io_ready, io_err, slv_sel, slv_read, slv_write, int_code all 0; io_rdata, slv_addr, slv_wdata = 0; timeout counter = 0. Reset mid-access aborts the access with no io_ready pulse.
- IDLE:
  - On io_read|io_write, register addr, wdata, size and op.
  - Decode by lowest matching index wins.
  - Match: go to ACCESS.
  - No match, or io_read and io_write both high: go to ERR.
- ACCESS:
  - slv_sel[i]=1 and slv_read or slv_write held each cycle; counter increments.
  - On slv_ready[i]: capture slv_rdata slice i (reads; 0 for writes) and go to RESP.
  - If counter reaches TIMEOUT (TIMEOUT>0) first: drop strobes, go to RESP with err=1.
  - slv_ready from unselected slaves is ignored.
- RESP: io_ready=1 for one cycle; io_err=err; io_rdata = captured data, or ERR_DATA if err. Strobes are already low. Next state DONE.
- ERR: same output as RESP with err=1 and io_rdata=ERR_DATA; next state DONE.
- DONE: wait until io_read=io_write=0, then go to IDLE. This prevents re-issue on a held request.
- Latency: request sampled at edge 0 → slv_sel high after edge 1 → slave ready sampled at edge k → io_ready high after edge k+1. Minimum is 3 cycles request-to-ready. Unmapped access completes with io_ready after edge 2.
- Interrupts:
  - int_code is registered every cycle from the current slv_int: priority encode, lowest index wins, value = index+1.
  - Follows deassertion one cycle later; independent of the bus FSM.
  - A code that does not fit INT_CODE_WIDTH is a parameter error (elaboration check).
- Counter width is clog2(TIMEOUT+1); it clears on entry to ACCESS.

Test Plan:
- Read: base1=0x1000_0000, mask=0xF000_0000; read 0x1000_0004, slave1 ready at its 3rd ACCESS cycle with 0x1234_5678 → slv_sel=4'b0010; io_ready one cycle with io_rdata=0x1234_5678, io_err=0; no second access while the request is held.
- Write: write 0xA5A5_A5A5, size 2 → slv_write=1, slv_wdata=0xA5A5_A5A5, slv_byte_size=2; io_ready pulses with io_err=0.
- Unmapped: read 0xF000_0000 → io_ready after 2 edges, io_err=1, io_rdata=0xDEAD_BEEF; slv_sel stays 0.
- Timeout: TIMEOUT=8, slave never ready → strobes drop after 8 ACCESS cycles; io_ready=1, io_err=1, io_rdata=0xDEAD_BEEF.
- Interrupts: slv_int=4'b1010 → int_code=2 the next cycle; clear bit1 → int_code=4; clear all → 0.
- Reset mid-access: rst=1 during ACCESS → next cycle all outputs 0 with no io_ready pulse; a new read after reset completes normally.
